// File: rtl/sram_zeroizer.sv
// sram_zeroizer: TL-UL host engine that bulk-clears a word-aligned SRAM region with capability-0
// full-word writes. Build macro SRAM_ZEROIZER_PATTERN_EN adds fill_pattern_i as the write data.

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic       capability;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Interleaved parity code: check bit j covers every 7th input bit starting at j.
    function automatic logic [6:0] intg_gen(input logic [56:0] v);
        logic [6:0] p;
        p = '0;
        for (int unsigned j = 0; j < 7; j++) begin
            for (int unsigned i = j; i < 57; i += 7) begin
                p[j] = p[j] ^ v[i];
            end
        end
        return p;
    endfunction

endpackage

module sram_zeroizer
    import tlul_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned CountWidth     = 16,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [AddrWidth-1:0]  base_addr_i,
    input  logic [CountWidth-1:0] num_words_i,
`ifdef SRAM_ZEROIZER_PATTERN_EN
    input  logic [31:0]           fill_pattern_i,
`endif
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  aborted_o,
    output logic [CountWidth-1:0] words_done_o,
    output tl_h2d_t               tl_o,
    input  tl_d2h_t               tl_i
);

    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [CountWidth-1:0] num_q, num_d;
    logic [CountWidth-1:0] issued_q, issued_d;
    logic [CountWidth-1:0] words_q, words_d;
    logic [OutW-1:0]       outst_q, outst_d;
    logic                  err_q, err_d;
    logic                  aborted_q, aborted_d;
    logic                  stop_q, stop_d;
    logic [31:0]           wdata;
    logic                  a_valid, a_fire, pending, d_fire;

`ifdef SRAM_ZEROIZER_PATTERN_EN
    logic [31:0] pattern_q, pattern_d;
    assign wdata = pattern_q;
`else
    assign wdata = 32'h0;
`endif

    always_comb begin
        // Counters only move on acceptance, so a stalled request stays stable.
        a_valid = (state_q == StIssue) && (issued_q != num_q) &&
                  (outst_q < OutW'(MaxOutstanding));
        a_fire  = a_valid & tl_i.a_ready;
        pending = a_valid & ~tl_i.a_ready;
        d_fire  = tl_i.d_valid & (outst_q != '0);

        state_d   = state_q;
        addr_d    = addr_q;
        num_d     = num_q;
        issued_d  = issued_q;
        words_d   = words_q;
        outst_d   = outst_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        stop_d    = stop_q;
`ifdef SRAM_ZEROIZER_PATTERN_EN
        pattern_d = pattern_q;
`endif

        if (a_fire) begin
            issued_d = issued_q + CountWidth'(1);
            addr_d   = addr_q + AddrWidth'(4);
        end
        unique case ({a_fire, d_fire})
            2'b10:   outst_d = outst_q + OutW'(1);
            2'b01:   outst_d = outst_q - OutW'(1);
            default: outst_d = outst_q;
        endcase
        if (d_fire) begin
            words_d = words_q + CountWidth'(1);
            err_d   = err_q | tl_i.d_error;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StIssue;
                    addr_d    = {base_addr_i[AddrWidth-1:2], 2'b00};
                    num_d     = num_words_i;
                    issued_d  = '0;
                    words_d   = '0;
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    stop_d    = 1'b0;
`ifdef SRAM_ZEROIZER_PATTERN_EN
                    pattern_d = fill_pattern_i;
`endif
                end
            end
            StIssue: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    stop_d    = 1'b1;
                end
                if (issued_q == num_q) begin
                    state_d = StDrain;
                end else if ((abort_i || stop_q) && !pending) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (outst_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            num_q     <= '0;
            issued_q  <= '0;
            words_q   <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            stop_q    <= 1'b0;
`ifdef SRAM_ZEROIZER_PATTERN_EN
            pattern_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            num_q     <= num_d;
            issued_q  <= issued_d;
            words_q   <= words_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            stop_q    <= stop_d;
`ifdef SRAM_ZEROIZER_PATTERN_EN
            pattern_q <= pattern_d;
`endif
        end
    end

    assign busy_o       = (state_q == StIssue) || (state_q == StDrain);
    assign done_o       = (state_q == StDone);
    assign err_o        = err_q;
    assign aborted_o    = aborted_q;
    assign words_done_o = words_q;

    always_comb begin
        tl_o                     = '0;
        tl_o.a_valid             = a_valid;
        tl_o.a_opcode            = PutFullData;
        tl_o.a_param             = 3'h0;
        tl_o.a_size              = 2'd2;
        tl_o.a_source            = 8'h0;
        tl_o.a_address           = 32'(addr_q);
        tl_o.a_mask              = 4'hF;
        tl_o.a_data              = wdata;
        tl_o.a_user.capability   = 1'b0;
        tl_o.a_user.cmd_intg     = intg_gen({17'h0, 1'b0, 3'(PutFullData), 4'hF, 32'(addr_q)});
        tl_o.a_user.data_intg    = intg_gen({25'h0, wdata});
        tl_o.d_ready             = 1'b1;
    end

    // Stray responses (e.g. from before a reset) are dropped; flag them in simulation.
    d_valid_unexpected_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        tl_i.d_valid |-> (outst_q != '0))
        else $error("sram_zeroizer: d_valid with no outstanding write");

endmodule

// File: tb/tb_sram_zeroizer.sv
// Directed bench for sram_zeroizer: an SRAM port-A responder with configurable stall, latency
// and error injection, plus a tag/data model of the cleared region.

module tb_sram_zeroizer;
    import tlul_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] num_words_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, err_o, aborted_o;
    logic [15:0] words_done_o;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;

    sram_zeroizer #(
        .AddrWidth      (32),
        .CountWidth     (16),
        .MaxOutstanding (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_words_i  (num_words_i),
`ifdef SRAM_ZEROIZER_PATTERN_EN
        .fill_pattern_i (32'h0),
`endif
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .aborted_o    (aborted_o),
        .words_done_o (words_done_o),
        .tl_o         (tl_o),
        .tl_i         (tl_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Responder / monitor state
    int          cyc = 0;
    int          resp_delay = 0;
    int          err_on_resp = 0;
    int          resp_n = 0;
    int          acc_cnt = 0;
    int          resp_cnt = 0;
    int          max_outst = 0;
    int          bad_fields = 0;
    int          hold_bad = 0;
    int          stalled = 0;
    int          stall_rem = 0;
    bit          stall_arm = 0;
    bit          abort_arm = 0;
    bit          held_valid = 0;
    tl_h2d_t     held;
    int          resp_q[$];
    logic [31:0] acc_addr[$];
    bit          tag_mem[logic [31:0]];
    logic [31:0] data_mem[logic [31:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_i);
            #2;
        end
    endtask

    task automatic clear_hist();
        acc_cnt = 0; resp_cnt = 0; max_outst = 0; bad_fields = 0; hold_bad = 0; stalled = 0;
        resp_n = 0; held_valid = 0;
        acc_addr.delete();
    endtask

    // Drive a start pulse; returns at the first sample after the start edge.
    task automatic start_sweep(input logic [31:0] base, input logic [15:0] num);
        tick();
        base_addr_i = base;
        num_words_i = num;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // lat counts samples since the start edge (1 = first sample after it).
    task automatic wait_done(input int limit, output int lat);
        lat = 1;
        while (!done_o && lat < limit) begin
            tick();
            lat++;
        end
        check("done_seen", {63'h0, done_o}, 64'h1);
    endtask

    // Responder and monitor: inputs driven at negedge, cycle observed 1 time unit later.
    initial begin
        tl_i = '0;
        tl_i.a_ready = 1'b1;
        tl_i.d_opcode = AccessAck;
        tl_i.d_size = 2'd2;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                resp_q.delete();
                tl_i.d_valid = 1'b0;
                tl_i.d_error = 1'b0;
                tl_i.a_ready = 1'b1;
                abort_i = 1'b0;
                stall_rem = 0;
            end else begin
                if (resp_q.size() > 0 && cyc >= resp_q[0] + 1 + resp_delay) begin
                    resp_n++;
                    tl_i.d_valid = 1'b1;
                    tl_i.d_error = (resp_n == err_on_resp);
                    void'(resp_q.pop_front());
                end else begin
                    tl_i.d_valid = 1'b0;
                    tl_i.d_error = 1'b0;
                end
                if (stall_rem > 0) begin
                    tl_i.a_ready = 1'b0;
                    stall_rem--;
                end else if (stall_arm && acc_cnt == 1) begin
                    stall_arm = 0;
                    stall_rem = 4;
                    tl_i.a_ready = 1'b0;
                end else begin
                    tl_i.a_ready = 1'b1;
                end
                if (abort_arm && acc_cnt == 2 && tl_o.a_valid) begin
                    abort_arm = 0;
                    abort_i = 1'b1;
                end else begin
                    abort_i = 1'b0;
                end
            end
            #1;
            if (rst_ni) begin
                if (tl_i.d_valid) resp_cnt++;
                if (tl_o.a_valid && tl_i.a_ready) begin
                    acc_cnt++;
                    acc_addr.push_back(tl_o.a_address);
                    resp_q.push_back(cyc);
                    tag_mem[tl_o.a_address] = tl_o.a_user.capability;
                    data_mem[tl_o.a_address] = tl_o.a_data;
                    if (tl_o.a_opcode !== PutFullData || tl_o.a_size !== 2'd2 ||
                        tl_o.a_mask !== 4'hF || tl_o.a_data !== 32'h0 ||
                        tl_o.a_source !== 8'h0 || tl_o.a_user.capability !== 1'b0) begin
                        bad_fields++;
                    end
                end
                if (tl_o.a_valid && !tl_i.a_ready) begin
                    stalled++;
                    if (held_valid && tl_o !== held) hold_bad++;
                    held = tl_o;
                    held_valid = 1;
                end else begin
                    held_valid = 0;
                end
                if (acc_cnt - resp_cnt > max_outst) max_outst = acc_cnt - resp_cnt;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc_before;

        // Reset values
        #1;
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_flags", {61'h0, done_o, err_o, aborted_o}, 64'h0);
        check("rst_words", {48'h0, words_done_o}, 64'h0);
        check("rst_a_valid", {63'h0, tl_o.a_valid}, 64'h0);
        check("rst_d_ready", {63'h0, tl_o.d_ready}, 64'h1);
        tick(2);
        rst_ni = 1'b1;
        tick(2);

        // Basic 8-word sweep over a region whose tags were set
        for (int i = 0; i < 8; i++) begin
            tag_mem[32'h0010_0000 + 32'(i * 4)] = 1'b1;
            data_mem[32'h0010_0000 + 32'(i * 4)] = 32'hDEAD_BEEF;
        end
        clear_hist();
        resp_delay = 0;
        start_sweep(32'h0010_0000, 16'd8);
        check("t1_busy_after_start", {63'h0, busy_o}, 64'h1);
        wait_done(100, lat);
        check("t1_busy_at_done", {63'h0, busy_o}, 64'h0);
        check("t1_words", {48'h0, words_done_o}, 64'd8);
        check("t1_err", {63'h0, err_o}, 64'h0);
        check("t1_accepts", 64'(acc_cnt), 64'd8);
        check("t1_fields", 64'(bad_fields), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_addr.size())
                check($sformatf("t1_addr%0d", i), {32'h0, acc_addr[i]}, 64'h0010_0000 + 64'(i * 4));
            check($sformatf("t1_mem%0d", i),
                  {31'h0, tag_mem[32'h0010_0000 + 32'(i * 4)],
                   data_mem[32'h0010_0000 + 32'(i * 4)]}, 64'h0);
        end
        tick();
        check("t1_done_pulse", {63'h0, done_o}, 64'h0);

        // Zero-length sweep
        clear_hist();
        start_sweep(32'h0000_1000, 16'd0);
        wait_done(20, lat);
        check("t2_latency", 64'(lat), 64'd3);
        check("t2_accepts", 64'(acc_cnt), 64'd0);
        check("t2_words", {48'h0, words_done_o}, 64'd0);

        // Stall on the second request with slow responses
        clear_hist();
        resp_delay = 4;
        stall_arm = 1;
        start_sweep(32'h0000_2000, 16'd16);
        wait_done(400, lat);
        check("t3_words", {48'h0, words_done_o}, 64'd16);
        check("t3_accepts", 64'(acc_cnt), 64'd16);
        check("t3_stall_cycles", 64'(stalled), 64'd5);
        check("t3_hold_stable", 64'(hold_bad), 64'd0);
        check("t3_max_outstanding", 64'(max_outst), 64'd2);
        check("t3_last_addr", {32'h0, acc_addr[15]}, 64'h0000_203C);

        // Abort alongside the third accepted write
        clear_hist();
        resp_delay = 0;
        abort_arm = 1;
        start_sweep(32'h0000_3000, 16'd100);
        wait_done(100, lat);
        check("t4_words", {48'h0, words_done_o}, 64'd3);
        check("t4_aborted", {63'h0, aborted_o}, 64'h1);
        tick(5);
        check("t4_no_more_accepts", 64'(acc_cnt), 64'd3);
        check("t4_idle", {62'h0, busy_o, tl_o.a_valid}, 64'h0);

        // Error on the second response
        clear_hist();
        err_on_resp = 2;
        start_sweep(32'h0000_4000, 16'd4);
        wait_done(100, lat);
        err_on_resp = 0;
        check("t5_words", {48'h0, words_done_o}, 64'd4);
        check("t5_err", {63'h0, err_o}, 64'h1);
        check("t5_aborted_cleared", {63'h0, aborted_o}, 64'h0);
        start_sweep(32'h0000_4000, 16'd0);
        check("t5_err_cleared", {63'h0, err_o}, 64'h0);
        wait_done(20, lat);

        // Address wrap with unaligned base
        clear_hist();
        start_sweep(32'hFFFF_FFFB, 16'd4);
        wait_done(100, lat);
        check("t6_accepts", 64'(acc_cnt), 64'd4);
        if (acc_addr.size() == 4) begin
            check("t6_addr0", {32'h0, acc_addr[0]}, 64'hFFFF_FFF8);
            check("t6_addr1", {32'h0, acc_addr[1]}, 64'hFFFF_FFFC);
            check("t6_addr2", {32'h0, acc_addr[2]}, 64'h0000_0000);
            check("t6_addr3", {32'h0, acc_addr[3]}, 64'h0000_0004);
        end

        // Reset in the middle of a sweep, then a fresh sweep
        clear_hist();
        resp_delay = 4;
        start_sweep(32'h0000_5000, 16'd100);
        tick(6);
        check("t7_busy_before_rst", {63'h0, busy_o}, 64'h1);
        rst_ni = 1'b0;
        #1;
        check("t7_busy_in_rst", {63'h0, busy_o}, 64'h0);
        check("t7_a_valid_in_rst", {63'h0, tl_o.a_valid}, 64'h0);
        check("t7_words_in_rst", {48'h0, words_done_o}, 64'h0);
        check("t7_d_ready_in_rst", {63'h0, tl_o.d_ready}, 64'h1);
        tick(3);
        rst_ni = 1'b1;
        tick(2);
        clear_hist();
        resp_delay = 0;
        acc_before = acc_cnt;
        start_sweep(32'h0000_6000, 16'd2);
        wait_done(50, lat);
        check("t7_recover_words", {48'h0, words_done_o}, 64'd2);
        check("t7_recover_accepts", 64'(acc_cnt - acc_before), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
